// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: digit count, hex segment table, scan FSM states.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    // Scan decoder frame states.
    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } seg_state_e;

    // Active-high g..a patterns; index is the hex value shown.
    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational lookup of a 7-bit active-high segment pattern into a hex nibble.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       match
);

    // Linear search of the hex table; a blank pattern never matches.
    always_comb begin
        nibble = 4'h0;
        match  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!match && pattern == SEG_HEX_TABLE[i]) begin
                nibble = 4'(i);
                match  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the displayed hex digits from a multiplexed active-low 6-digit LED scan.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned FRAME_TIMEOUT = 1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [5:0]  seg_sel,
    input  logic [7:0]  seg_led,
    output logic [23:0] digit_val,
    output logic [5:0]  dp_val,
    output logic [5:0]  seg_err,
    output logic        frame_valid,
    output logic        timeout
);

    localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);

    logic [5:0]  sel_q;
    logic [7:0]  led_q;
    logic [13:0] prev_q;
    logic [7:0]  run_q, run_d;
    logic [5:0]  sel_oh;
    logic        same, sample;
    logic [3:0]  nibble;
    logic        match;

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_hit, timeout_d;

    seg_state_e state_q, state_d;
    logic [5:0] mask_q, mask_d;
    logic       emit;

    logic [23:0] sh_val_q;
    logic [5:0]  sh_dp_q, sh_err_q;

    assign sel_oh = ~sel_q;
    assign same   = ({sel_q, led_q} == prev_q);
    // Run length reaches STABLE_CYCLES this cycle; saturation keeps it from re-firing.
    assign sample = same && (run_q == 8'(STABLE_CYCLES - 1)) && $onehot(sel_oh);
    assign run_d  = !same ? 8'd1 : ((run_q == 8'hFF) ? run_q : run_q + 8'd1);
    assign to_hit = !sample && (to_cnt_q == TW'(FRAME_TIMEOUT - 1));

    seg_pattern_decode u_decode (
        .pattern (~led_q[6:0]),
        .nibble  (nibble),
        .match   (match)
    );

    // Input registers and stability run counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sel_q  <= '0;
            led_q  <= '0;
            prev_q <= '0;
            run_q  <= '0;
        end else begin
            sel_q  <= seg_sel;
            led_q  <= seg_led;
            prev_q <= {sel_q, led_q};
            run_q  <= run_d;
        end
    end

    // Shadow capture of the sampled digit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_err_q <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sample && sel_oh[i]) begin
                    sh_val_q[4*i +: 4] <= match ? nibble : 4'h0;
                    sh_dp_q[i]         <= ~led_q[7];
                    sh_err_q[i]        <= ~match;
                end
            end
        end
    end

    // Timeout counter: cycles since the last sample, saturating at FRAME_TIMEOUT.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout;
        if (sample) begin
            to_cnt_d  = TW'(1);
            timeout_d = 1'b0;
        end else begin
            if (to_cnt_q != TW'(FRAME_TIMEOUT)) begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
            if (to_hit) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Frame FSM next-state and collected-mask logic.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        emit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample) begin
                    state_d = COLLECT;
                    mask_d  = mask_q | sel_oh;
                end
            end
            COLLECT: begin
                if (sample) begin
                    mask_d = mask_q | sel_oh;
                end
                if (mask_d == 6'h3F) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                emit    = 1'b1;
                // A sample landing here starts the next frame.
                mask_d  = sample ? sel_oh : 6'h00;
                state_d = COLLECT;
            end
            default: begin
                state_d = IDLE;
                mask_d  = 6'h00;
            end
        endcase
        if (to_hit) begin
            state_d = IDLE;
            mask_d  = 6'h00;
            emit    = 1'b0;
        end
    end

    // State, timeout and output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            to_cnt_q    <= '0;
            timeout     <= 1'b0;
            digit_val   <= '0;
            dp_val      <= '0;
            seg_err     <= 6'h3F;
            frame_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            to_cnt_q    <= to_cnt_d;
            timeout     <= timeout_d;
            frame_valid <= emit;
            if (emit) begin
                digit_val <= sh_val_q;
                dp_val    <= sh_dp_q;
                seg_err   <= sh_err_q;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE_CYCLES = 8, FRAME_TIMEOUT = 100.
module tb_seg_scan_decoder;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_led;
    logic [23:0] digit_val;
    logic [5:0]  dp_val;
    logic [5:0]  seg_err;
    logic        frame_valid;
    logic        timeout;

    int checks = 0;
    int passes = 0;
    int fv_count = 0;
    int fv_base;

    logic [6:0] hex_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_scan_decoder #(
        .STABLE_CYCLES (8),
        .FRAME_TIMEOUT (100)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .seg_sel     (seg_sel),
        .seg_led     (seg_led),
        .digit_val   (digit_val),
        .dp_val      (dp_val),
        .seg_err     (seg_err),
        .frame_valid (frame_valid),
        .timeout     (timeout)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (frame_valid) fv_count <= fv_count + 1;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] sel, input logic [7:0] led, input int cycles);
        seg_sel = sel;
        seg_led = led;
        tick(cycles);
    endtask

    // val 16 means blank digit.
    task automatic show(input int idx, input int val, input bit dp, input int cycles);
        logic [5:0] one;
        logic [6:0] pat;
        one = 6'b000001;
        pat = (val < 16) ? hex_tbl[val] : 7'h00;
        drive(~(one << idx), ~{dp, pat}, cycles);
    endtask

    task automatic scan_frame(input logic [23:0] v);
        for (int i = 5; i >= 0; i--) begin
            show(i, int'(v[4*i +: 4]), 1'b0, 20);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        seg_sel = 6'h3F;
        seg_led = 8'hFF;
        tick(3);
        sys_rst = 1'b0;
        tick(1);

        check("rst_digit_val", 32'(digit_val), 32'h0);
        check("rst_dp_val", 32'(dp_val), 32'h0);
        check("rst_seg_err", 32'(seg_err), 32'h3F);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);

        // Plain "123456".
        scan_frame(24'h123456);
        check("f1_count", 32'(fv_count), 32'd1);
        check("f1_digit_val", 32'(digit_val), 32'h123456);
        check("f1_seg_err", 32'(seg_err), 32'h0);
        check("f1_dp_val", 32'(dp_val), 32'h0);

        // dp on digit 2, digit 4 blank.
        show(5, 9, 1'b0, 20);
        show(4, 16, 1'b0, 20);
        show(3, 10, 1'b0, 20);
        show(2, 11, 1'b1, 20);
        show(1, 12, 1'b0, 20);
        show(0, 13, 1'b0, 20);
        check("f2_count", 32'(fv_count), 32'd2);
        check("f2_digit_val", 32'(digit_val), 32'h90ABCD);
        check("f2_dp_val", 32'(dp_val), 32'b000100);
        check("f2_seg_err", 32'(seg_err), 32'b010000);

        // Short glitches and a two-digit-select run must not sample.
        show(5, 1, 1'b0, 20);
        show(0, 8, 1'b0, 5);
        show(4, 2, 1'b0, 20);
        drive(6'b111100, 8'h80, 20);
        show(3, 3, 1'b0, 20);
        show(5, 15, 1'b0, 5);
        show(2, 4, 1'b0, 20);
        show(1, 5, 1'b0, 20);
        show(3, 14, 1'b1, 5);
        show(0, 6, 1'b0, 20);
        check("f3_count", 32'(fv_count), 32'd3);
        check("f3_digit_val", 32'(digit_val), 32'h123456);
        check("f3_seg_err", 32'(seg_err), 32'h0);
        check("f3_dp_val", 32'(dp_val), 32'h0);

        // Digit 0 re-sampled before the frame completes.
        show(0, 7, 1'b0, 20);
        show(5, 1, 1'b0, 20);
        show(0, 8, 1'b0, 20);
        check("f4_no_early", 32'(fv_count), 32'd3);
        show(4, 2, 1'b0, 20);
        show(3, 3, 1'b0, 20);
        show(2, 4, 1'b0, 20);
        show(1, 5, 1'b0, 20);
        check("f4_count", 32'(fv_count), 32'd4);
        check("f4_digit_val", 32'(digit_val), 32'h123458);

        // Scan stalls after three digits; last sample registers at edge 9 of the dwell.
        show(5, 9, 1'b0, 20);
        show(4, 9, 1'b0, 20);
        show(3, 9, 1'b0, 107);
        check("to_before", 32'(timeout), 32'h0);
        tick(1);
        check("to_raised", 32'(timeout), 32'h1);
        check("to_no_frame", 32'(fv_count), 32'd4);
        check("to_hold_val", 32'(digit_val), 32'h123458);

        // Recovery: timeout clears the cycle after the next sample; partial frame discarded.
        show(0, 10, 1'b0, 8);
        check("to_still_set", 32'(timeout), 32'h1);
        tick(1);
        check("to_cleared", 32'(timeout), 32'h0);
        tick(11);
        show(1, 11, 1'b0, 20);
        show(2, 12, 1'b0, 20);
        show(3, 13, 1'b0, 20);
        show(4, 14, 1'b0, 20);
        check("to_mask_cleared", 32'(fv_count), 32'd4);
        show(5, 15, 1'b0, 20);
        check("f5_count", 32'(fv_count), 32'd5);
        check("f5_digit_val", 32'(digit_val), 32'hFEDCBA);

        // Reset mid-frame.
        show(0, 1, 1'b0, 20);
        show(1, 2, 1'b0, 20);
        show(2, 3, 1'b0, 20);
        show(3, 4, 1'b0, 20);
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        check("mr_digit_val", 32'(digit_val), 32'h0);
        check("mr_dp_val", 32'(dp_val), 32'h0);
        check("mr_seg_err", 32'(seg_err), 32'h3F);
        check("mr_timeout", 32'(timeout), 32'h0);
        fv_base = fv_count;
        show(5, 1, 1'b0, 20);
        show(4, 2, 1'b0, 20);
        show(3, 3, 1'b0, 20);
        show(2, 4, 1'b0, 20);
        show(1, 5, 1'b0, 20);
        check("mr_no_frame", 32'(fv_count - fv_base), 32'd0);
        show(0, 6, 1'b0, 20);
        check("mr_count", 32'(fv_count - fv_base), 32'd1);
        check("mr_digit_val2", 32'(digit_val), 32'h123456);
        check("mr_seg_err2", 32'(seg_err), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
